// File: rtl/auto_contrast_ctrl_pkg.sv
// Shared types, widths and constants for the auto-contrast controller.
package auto_contrast_ctrl_pkg;

    localparam int unsigned LUMA_W     = 8;
    localparam int unsigned DIVIDEND_W = 10;
    localparam int unsigned GAIN_W     = 8;
    localparam int unsigned PROD_W     = 16;
    localparam int unsigned CNT_W      = 4;

    localparam logic [DIVIDEND_W-1:0] DIVIDEND   = 10'd1020;
    localparam logic [CNT_W-1:0]      DIV_CYCLES = 4'd10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgbT;

    typedef enum logic [1:0] {IDLE, DIVIDE, APPLY} ctrlStateT;

    // Y = (R + 2G + B) >> 2, truncating
    function automatic logic [LUMA_W-1:0] lumaOf(input rgbT px);
        logic [DIVIDEND_W-1:0] sum;
        sum = DIVIDEND_W'(px.r) + DIVIDEND_W'({px.g, 1'b0}) + DIVIDEND_W'(px.b);
        return LUMA_W'(sum >> 2);
    endfunction

endpackage

// File: rtl/auto_contrast_ctrl_if.sv
// Pixel stream in, contrast/brightness parameters out.
interface auto_contrast_ctrl_if;
    import auto_contrast_ctrl_pkg::*;

    rgbT        tRGB;
    logic       pix_valid;
    logic       frame_start;
    logic       frame_end;
    logic [7:0] contrast;
    logic [7:0] brightness;
    logic       params_valid;
    logic       busy;
    logic       overrun;

    modport master (
        output tRGB, pix_valid, frame_start, frame_end,
        input  contrast, brightness, params_valid, busy, overrun
    );

    modport slave (
        input  tRGB, pix_valid, frame_start, frame_end,
        output contrast, brightness, params_valid, busy, overrun
    );

endinterface

// File: rtl/auto_contrast_ctrl_divider.sv
// Restoring divider: one quotient bit per clock, done pulses after DIV_CYCLES iterations.
module seq_divider_10x8
    import auto_contrast_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [LUMA_W-1:0]     divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  divByZero
);

    logic [LUMA_W-1:0] dvs;
    logic [LUMA_W-1:0] rem;
    logic [CNT_W-1:0]  cnt;
    logic              running;
    logic [LUMA_W:0]   remShift_c;
    logic [LUMA_W-1:0] diff_c;
    logic              qBit_c;

    // quotient doubles as the dividend shift register while running
    always_comb begin
        remShift_c = {rem, quotient[DIVIDEND_W-1]};
        qBit_c     = remShift_c >= {1'b0, dvs};
        diff_c     = LUMA_W'(remShift_c - {1'b0, dvs});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                rem       <= '0;
                dvs       <= divisor;
                cnt       <= DIV_CYCLES;
                running   <= 1'b1;
                divByZero <= (divisor == '0);
            end else if (running) begin
                rem      <= qBit_c ? diff_c : LUMA_W'(remShift_c);
                quotient <= {quotient[DIVIDEND_W-2:0], qBit_c};
                cnt      <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/auto_contrast_ctrl.sv
// Per-frame luma min/max measurement and contrast/brightness computation.
module auto_contrast_ctrl
    import auto_contrast_ctrl_pkg::*;
#(
    parameter logic [GAIN_W-1:0] MIN_GAIN = 8'd4,
    parameter logic [GAIN_W-1:0] MAX_GAIN = 8'd32
)(
    input  logic                 clk,
    input  logic                 reset_n,
    auto_contrast_ctrl_if.slave  vid
);

    logic [LUMA_W-1:0]     yC, minR, maxR, minMerged_c, maxMerged_c, snapMax;
    logic                  seenR, seenMerged_c, divStart_c;
    logic                  divDone, divZero;
    logic [DIVIDEND_W-1:0] divQuot, quot_c;
    logic [GAIN_W-1:0]     gain_c, contrastR, brightR, bright_c;
    logic [PROD_W-1:0]     scaled_c;
    logic                  pvR, busyR, overrunR;
    ctrlStateT             state;

    // running stats including this cycle's pixel, used both to accumulate and to close a frame
    always_comb begin
        yC           = lumaOf(vid.tRGB);
        minMerged_c  = minR;
        maxMerged_c  = maxR;
        seenMerged_c = seenR | vid.pix_valid;
        if (vid.pix_valid) begin
            minMerged_c = (seenR && minR < yC) ? minR : yC;
            maxMerged_c = (seenR && maxR > yC) ? maxR : yC;
        end
        divStart_c = vid.frame_end && seenMerged_c && !busyR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            minR  <= '0;
            maxR  <= '0;
            seenR <= 1'b0;
        end else if (vid.frame_start) begin
            seenR <= vid.pix_valid;
            minR  <= vid.pix_valid ? yC : '1;
            maxR  <= vid.pix_valid ? yC : '0;
        end else if (vid.pix_valid) begin
            seenR <= 1'b1;
            minR  <= minMerged_c;
            maxR  <= maxMerged_c;
        end
    end

    seq_divider_10x8 uDiv (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (divStart_c),
        .dividend  (DIVIDEND),
        .divisor   (maxMerged_c - minMerged_c),
        .done      (divDone),
        .quotient  (divQuot),
        .divByZero (divZero)
    );

    // gain clamp and brightness offset that keeps max_snap*gain at full scale
    always_comb begin
        quot_c = divZero ? DIVIDEND_W'(MAX_GAIN) : divQuot;
        if (quot_c < DIVIDEND_W'(MIN_GAIN))      gain_c = MIN_GAIN;
        else if (quot_c > DIVIDEND_W'(MAX_GAIN)) gain_c = MAX_GAIN;
        else                                     gain_c = GAIN_W'(quot_c);
        scaled_c = (PROD_W'(snapMax) * PROD_W'(gain_c)) >> 2;
        bright_c = (scaled_c >= PROD_W'(255)) ? '0 : GAIN_W'(PROD_W'(255) - scaled_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            snapMax   <= '0;
            contrastR <= MIN_GAIN;
            brightR   <= '0;
            pvR       <= 1'b0;
            busyR     <= 1'b0;
            overrunR  <= 1'b0;
        end else begin
            pvR <= 1'b0;
            if (vid.frame_end && busyR) overrunR <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (divStart_c) begin
                        snapMax <= maxMerged_c;
                        busyR   <= 1'b1;
                        state   <= DIVIDE;
                    end else if (pvR) begin
                        busyR <= 1'b0;
                    end
                end
                DIVIDE: if (divDone) state <= APPLY;
                APPLY: begin
                    contrastR <= gain_c;
                    brightR   <= bright_c;
                    pvR       <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign vid.contrast     = contrastR;
    assign vid.brightness   = brightR;
    assign vid.params_valid = pvR;
    assign vid.busy         = busyR;
    assign vid.overrun      = overrunR;

endmodule
